sem_pipe_arbiter: RTL

SEM_PIPE_ARBITER -- requirements
Module: sem_pipe_arbiter

---
 rtl/sem_pipe_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sem_pipe_arbiter.sv
// Key-limited pipelined request arbiter: grants one channel per cycle, carries the payload
// through STAGES registers, and stops after TXN_LIMIT transactions. Define SEM_PIPE_RR_EN for round-robin.
module sem_pipe_arbiter #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int STAGES    = 3,
    parameter int KEYS      = 2,
    parameter int TXN_LIMIT = 16,
    parameter int CNT_W     = 8,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int KF_W     = $clog2(KEYS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          gnt,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic [CNT_W-1:0]         count,
    output logic [KF_W-1:0]          keys_free,
    output logic                     done
);

    localparam int ACC_W = $clog2(TXN_LIMIT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc_cnt;
    logic [KF_W-1:0]     in_flight;
    logic [CNT_W-1:0]    count_q;
    logic                done_q;
    logic [STAGES-1:0]   vld;
    logic [ADDR_W-1:0]   addr_q [STAGES];
    logic [DATA_W-1:0]   data_q [STAGES];
    logic [CH_W-1:0]     ch_q   [STAGES];
`ifdef SEM_PIPE_RR_EN
    logic [CH_W-1:0]     rr_ptr;   // channel with top priority on the next search
`endif

    logic                win_found;
    logic [CH_W-1:0]     win;
    logic                accept;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win       = '0;
        idx       = 0;
`ifdef SEM_PIPE_RR_EN
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = CH_W'(idx);
            end
        end
`else
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win       = CH_W'(i);
            end
        end
`endif
    end

    // A retiring transaction returns its key in the same cycle, so a full pool can still grant.
    assign accept = rst_n && (state == RUN) && win_found &&
                    ((in_flight != KF_W'(KEYS)) || vld[STAGES-1]);
    assign gnt    = accept ? (N_CH'(1) << win) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload stages are cleared too because the last stage drives out_addr/out_data/out_ch,
            // which must read zero after reset; a deeper payload-only RAM would not need this.
            vld       <= '0;
            for (int s = 0; s < STAGES; s++) begin
                addr_q[s] <= '0;
                data_q[s] <= '0;
                ch_q[s]   <= '0;
            end
            state     <= RUN;
            acc_cnt   <= '0;
            in_flight <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
`ifdef SEM_PIPE_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            vld[0]    <= accept;
            addr_q[0] <= req_addr[win*ADDR_W +: ADDR_W];
            data_q[0] <= req_data[win*DATA_W +: DATA_W];
            ch_q[0]   <= win;
            for (int s = 1; s < STAGES; s++) begin
                vld[s]    <= vld[s-1];
                addr_q[s] <= addr_q[s-1];
                data_q[s] <= data_q[s-1];
                ch_q[s]   <= ch_q[s-1];
            end

            if (accept && !vld[STAGES-1])
                in_flight <= in_flight + 1'b1;
            else if (!accept && vld[STAGES-1])
                in_flight <= in_flight - 1'b1;

            if (vld[STAGES-1])
                count_q <= count_q + 1'b1;

            case (state)
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt == ACC_W'(TXN_LIMIT - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (vld[STAGES-1] && (in_flight == KF_W'(1))) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase

`ifdef SEM_PIPE_RR_EN
            if (accept)
                rr_ptr <= (win == CH_W'(N_CH - 1)) ? '0 : win + 1'b1;
`endif
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_addr  = addr_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_ch    = ch_q[STAGES-1];
    assign count     = count_q;
    assign keys_free = KF_W'(KEYS) - in_flight;
    assign done      = done_q;

endmodule
